// File: rtl/ap_pkg.sv
// Shared definitions for the AP program sequencer:
// opcodes, ISA field widths and sequencer state encoding.
package ap_pkg;

    localparam int OPC_W = 4;
    localparam int ISA_W = 30;

    localparam logic [OPC_W-1:0] INS_VALID_ALL = '1;

    localparam logic [OPC_W-1:0] OP_RESET    = 4'd0;
    localparam logic [OPC_W-1:0] OP_LOADRBR  = 4'd1;
    localparam logic [OPC_W-1:0] OP_RET      = 4'd2;
    localparam logic [OPC_W-1:0] OP_LOADR    = 4'd3;
    localparam logic [OPC_W-1:0] OP_STORER   = 4'd4;
    localparam logic [OPC_W-1:0] OP_STORERBR = 4'd5;
    localparam logic [OPC_W-1:0] OP_ADD      = 4'd6;
    localparam logic [OPC_W-1:0] OP_SUB      = 4'd7;
    localparam logic [OPC_W-1:0] OP_MUL      = 4'd8;
    localparam logic [OPC_W-1:0] OP_DIV      = 4'd9;
    localparam logic [OPC_W-1:0] OP_AND      = 4'd10;
    localparam logic [OPC_W-1:0] OP_OR       = 4'd11;
    localparam logic [OPC_W-1:0] OP_XOR      = 4'd12;
    localparam logic [OPC_W-1:0] OP_SHL      = 4'd13;
    localparam logic [OPC_W-1:0] OP_SHR      = 4'd14;
    localparam logic [OPC_W-1:0] OP_ABS      = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } seq_state_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for interrupt entry/return.
// Push and pop are never requested in the same cycle.
module pc_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty,
    output logic [SPW-1:0]   sp
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp_dec;

    assign sp_dec = sp - 1'b1;
    assign top    = mem[sp_dec[IDXW-1:0]];
    assign full   = (sp == SP_FULL);
    assign empty  = (sp == '0);

    // Stack pointer: cleared on restart, moves on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (clr) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end

    // Entry storage; contents are only meaningful below sp.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem[sp[IDXW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ap_pc_seq.sv
// Program sequencer between ins_cache and the AP controller:
// fetch, decode of RET, issue handshake and interrupt entry.
module ap_pc_seq
    import ap_pkg::*;
#(
    parameter int          ADDR_WIDTH_MEM  = 16,
    parameter int          OPCODE_WIDTH    = OPC_W,
    parameter int          ISA_WIDTH       = ISA_W,
    parameter int          TOTAL_ISA_DEPTH = 128,
    parameter int unsigned INT_BASE        = 32'h8000,
    parameter int          STACK_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    output logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    input  logic                      ins_cache_rdy,
    input  logic [OPCODE_WIDTH-1:0]   ins_valid,
    input  logic [ISA_WIDTH-1:0]      instruction,
    output logic [ISA_WIDTH-1:0]      ins_out,
    output logic                      ins_out_valid,
    input  logic                      ins_out_ready,
    input  logic                      int_req,
    output logic                      int_ack,
    output logic                      stack_ovf
);

    localparam int AW  = ADDR_WIDTH_MEM;
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    localparam logic [AW-1:0]  PC_FIRST = AW'(1);
    localparam logic [AW-1:0]  PC_LAST  = AW'(TOTAL_ISA_DEPTH);
    localparam logic [AW-1:0]  PC_INT   = AW'(INT_BASE);
    localparam logic [SPW-1:0] SP_FULL  = SPW'(STACK_DEPTH);

    seq_state_e state, state_n;

    logic [AW-1:0]           pc, pc_n, pc_inc, addr_n;
    logic [ISA_WIDTH-1:0]    ins_q, ins_q_n, ins_out_n;
    logic                    ins_out_valid_n, int_ack_n, stack_ovf_n;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    cache_idle, ins_hit, is_ret;
    logic                    stk_clr, stk_push, stk_pop;
    logic                    stk_full, stk_empty;
    logic [AW-1:0]           stk_top;
    logic [SPW-1:0]          stk_sp;

    assign pc_inc     = pc + 1'b1;
    assign opcode     = ins_q[ISA_WIDTH-1 -: OPCODE_WIDTH];
    assign is_ret     = (opcode == OPCODE_WIDTH'(OP_RET));
    assign cache_idle = ins_cache_rdy && (ins_valid == '0);
    assign ins_hit    = (ins_valid == '1);
    assign done       = (state == S_HALT);

    pc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (AW),
        .SPW   (SPW)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty),
        .sp    (stk_sp)
    );

    // Next-state, next-pc and handshake outputs.
    always_comb begin
        state_n         = state;
        pc_n            = pc;
        addr_n          = addr_ins;
        ins_q_n         = ins_q;
        ins_out_n       = ins_out;
        ins_out_valid_n = ins_out_valid;
        int_ack_n       = 1'b0;
        stack_ovf_n     = stack_ovf;
        stk_clr         = 1'b0;
        stk_push        = 1'b0;
        stk_pop         = 1'b0;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_n        = PC_FIRST;
                    stk_clr     = 1'b1;
                    stack_ovf_n = 1'b0;
                    state_n     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (cache_idle) begin
                    addr_n  = pc;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ins_hit) begin
                    ins_q_n = instruction;
                    addr_n  = '0;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_ret) begin
                    if (!stk_empty) begin
                        stk_pop = 1'b1;
                        pc_n    = stk_top;
                        state_n = (stk_top == '0) ? S_HALT : S_FETCH;
                    end else begin
                        state_n = S_HALT;
                    end
                end else begin
                    ins_out_n       = ins_q;
                    ins_out_valid_n = 1'b1;
                    state_n         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ins_out_ready) begin
                    ins_out_valid_n = 1'b0;
                    if (int_req && !stk_full) begin
                        stk_push  = 1'b1;
                        pc_n      = PC_INT;
                        int_ack_n = 1'b1;
                        state_n   = S_FETCH;
                    end else begin
                        if (int_req && stk_sp == SP_FULL) begin
                            stack_ovf_n = 1'b1;
                        end
                        if (pc == PC_LAST && pc < PC_INT) begin
                            state_n = S_HALT;
                        end else begin
                            pc_n    = pc_inc;
                            state_n = (pc_inc == '0) ? S_HALT : S_FETCH;
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            pc            <= PC_FIRST;
            addr_ins      <= '0;
            ins_q         <= '0;
            ins_out       <= '0;
            ins_out_valid <= 1'b0;
            int_ack       <= 1'b0;
            stack_ovf     <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            addr_ins      <= addr_n;
            ins_q         <= ins_q_n;
            ins_out       <= ins_out_n;
            ins_out_valid <= ins_out_valid_n;
            int_ack       <= int_ack_n;
            stack_ovf     <= stack_ovf_n;
        end
    end

endmodule

// File: tb/tb_ap_pc_seq.sv
// Directed bench for ap_pc_seq: cache model, issue monitor,
// hand-built expected fetch/issue logs.
module tb_ap_pc_seq;
    import ap_pkg::*;

    localparam int ACK = 32'h10000;
    localparam int OVF = 32'h20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] addr_ins;
    logic        ins_cache_rdy = 1'b1;
    logic [3:0]  ins_valid = 4'h0;
    logic [29:0] instruction = '0;
    logic [29:0] ins_out;
    logic        ins_out_valid;
    logic        ins_out_ready = 1'b1;
    logic        int_req = 1'b0;
    logic        int_ack;
    logic        stack_ovf;

    int n_chk = 0;
    int n_pass = 0;

    bit is_ret [int];
    int fetched[$];
    int issued[$];
    int exp_f[$];
    int exp_i[$];

    bit stale = 1'b0;
    int bp_addr = 0;
    int bp_left = 0;
    int bp_bad = 0;
    int gap_bad = 0;
    int int_a = 0;
    int left_a = 0;
    int int_b = 0;
    int left_b = 0;
    logic [15:0] prev_addr = '0;
    logic        prev_ovf = 1'b0;

    ap_pc_seq dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .addr_ins      (addr_ins),
        .ins_cache_rdy (ins_cache_rdy),
        .ins_valid     (ins_valid),
        .instruction   (instruction),
        .ins_out       (ins_out),
        .ins_out_valid (ins_out_valid),
        .ins_out_ready (ins_out_ready),
        .int_req       (int_req),
        .int_ack       (int_ack),
        .stack_ovf     (stack_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] word(input logic [15:0] a);
        logic [3:0] op;
        op = is_ret.exists(int'(a)) ? OP_RET : OP_ADD;
        return {op, 10'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Cache model: serves one word per request, then idles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stale) begin
                ins_valid = 4'hF;
            end else if (ins_valid != 4'h0) begin
                ins_valid = 4'h0;
            end else if (addr_ins != '0) begin
                instruction = word(addr_ins);
                ins_valid   = 4'hF;
            end
        end
    end

    // Controller model and log monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (addr_ins != '0 && addr_ins != prev_addr) begin
                fetched.push_back(int'(addr_ins));
                if (prev_addr != '0) gap_bad++;
            end
            prev_addr = addr_ins;
            if (int_ack) fetched.push_back(ACK);
            if (stack_ovf && !prev_ovf) fetched.push_back(OVF);
            prev_ovf = stack_ovf;
            if (ins_out_valid && int'(ins_out[15:0]) == bp_addr &&
                bp_left > 0) begin
                ins_out_ready = 1'b0;
                bp_left--;
                if (ins_out != word(ins_out[15:0]) || addr_ins != '0)
                    bp_bad++;
            end else begin
                ins_out_ready = 1'b1;
            end
            int_req = 1'b0;
            if (ins_out_valid && ins_out_ready) begin
                if (int'(ins_out[15:0]) == int_a && left_a > 0) begin
                    int_req = 1'b1;
                    left_a--;
                end else if (int'(ins_out[15:0]) == int_b && left_b > 0) begin
                    int_req = 1'b1;
                    left_b--;
                end
                issued.push_back(int'(ins_out[15:0]));
            end
        end
    end

    task automatic clear_logs();
        fetched.delete();
        issued.delete();
        exp_f.delete();
        exp_i.delete();
        is_ret.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic cmp_logs(input string tag);
        int bf;
        int bi;
        bf = 0;
        bi = 0;
        chk({tag, "_flen"}, fetched.size(), exp_f.size());
        for (int i = 0; i < fetched.size() && i < exp_f.size(); i++)
            if (fetched[i] != exp_f[i]) bf++;
        chk({tag, "_fseq"}, bf, 0);
        chk({tag, "_ilen"}, issued.size(), exp_i.size());
        for (int i = 0; i < issued.size() && i < exp_i.size(); i++)
            if (issued[i] != exp_i[i]) bi++;
        chk({tag, "_iseq"}, bi, 0);
    endtask

    initial begin
        int n;

        repeat (3) @(negedge clk);
        chk("rst_addr", addr_ins, 0);
        chk("rst_ins_out", ins_out, 0);
        chk("rst_valid", ins_out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ack", int_ack, 0);
        chk("rst_ovf", stack_ovf, 0);
        rst = 1'b0;

        // Full program with backpressure at address 5.
        clear_logs();
        bp_addr = 5;
        bp_left = 10;
        for (int a = 1; a <= 128; a++) begin
            exp_f.push_back(a);
            exp_i.push_back(a);
        end
        pulse_start();
        wait_done("prog", 1000);
        cmp_logs("prog");
        chk("prog_gap", gap_bad, 0);
        chk("bp_stable", bp_bad, 0);
        chk("bp_used", bp_left, 0);
        repeat (3) @(negedge clk);
        chk("done_hold", done, 1);
        chk("halt_valid", ins_out_valid, 0);
        chk("halt_addr", addr_ins, 0);

        // Stale valid and cache-not-ready hold off the first fetch.
        clear_logs();
        stale = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        chk("start_clr_done", done, 0);
        repeat (4) @(negedge clk);
        chk("stale_hold", addr_ins, 0);
        ins_cache_rdy = 1'b0;
        stale = 1'b0;
        repeat (3) @(negedge clk);
        chk("rdy_hold", addr_ins, 0);
        ins_cache_rdy = 1'b1;
        n = 0;
        while (addr_ins == '0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("stale_fetch", addr_ins, 1);

        // Reset in WAIT clears outputs immediately.
        rst = 1'b1;
        #1;
        chk("mid_rst_addr", addr_ins, 0);
        chk("mid_rst_valid", ins_out_valid, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_idle", addr_ins, 0);

        // Single interrupt at address 10.
        clear_logs();
        gap_bad = 0;
        is_ret[32'h8002] = 1'b1;
        int_a = 10;
        left_a = 1;
        for (int a = 1; a <= 10; a++) begin
            exp_f.push_back(a);
            exp_i.push_back(a);
        end
        exp_f.push_back(ACK);
        exp_f.push_back(32'h8000);
        exp_f.push_back(32'h8001);
        exp_f.push_back(32'h8002);
        exp_i.push_back(32'h8000);
        exp_i.push_back(32'h8001);
        for (int a = 11; a <= 128; a++) begin
            exp_f.push_back(a);
            exp_i.push_back(a);
        end
        pulse_start();
        wait_done("irq", 1000);
        cmp_logs("irq");
        chk("irq_gap", gap_bad, 0);
        chk("irq_ovf", stack_ovf, 0);

        // Five nested requests: fifth is refused, four RETs unwind.
        clear_logs();
        is_ret[32'h8002] = 1'b1;
        int_a = 10;
        left_a = 1;
        int_b = 32'h8000;
        left_b = 4;
        for (int a = 1; a <= 10; a++) begin
            exp_f.push_back(a);
            exp_i.push_back(a);
        end
        for (int k = 0; k < 4; k++) begin
            exp_f.push_back(ACK);
            exp_f.push_back(32'h8000);
            exp_i.push_back(32'h8000);
        end
        exp_f.push_back(OVF);
        for (int k = 0; k < 4; k++) begin
            exp_f.push_back(32'h8001);
            exp_f.push_back(32'h8002);
            exp_i.push_back(32'h8001);
        end
        for (int a = 11; a <= 128; a++) begin
            exp_f.push_back(a);
            exp_i.push_back(a);
        end
        pulse_start();
        wait_done("nest", 1500);
        cmp_logs("nest");
        chk("nest_ovf", stack_ovf, 1);
        int_b = 0;

        // RET at top level halts the program.
        clear_logs();
        is_ret[3] = 1'b1;
        exp_f = '{1, 2, 3};
        exp_i = '{1, 2};
        pulse_start();
        chk("start_clr_ovf", stack_ovf, 0);
        wait_done("ret", 200);
        cmp_logs("ret");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
